// File: rtl/blob_tracker.sv
// Blob tracker: accumulates detector hits over a video frame, then reports
// the hit count, bounding box and (for large enough blobs) the centroid.
// The centroid is computed by a serial restoring divider, x first, then y.
module blob_tracker #(
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned X_LIMIT    = 640,
  parameter int unsigned Y_LIMIT    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_VS,
  input  logic        pixel_valid,
  input  logic        hit,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic [9:0]  bbox_x_min,
  output logic [9:0]  bbox_x_max,
  output logic [9:0]  bbox_y_min,
  output logic [9:0]  bbox_y_max,
  output logic [18:0] pixel_count,
  output logic        found,
  output logic        result_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  localparam logic [10:0] XLim      = 11'(X_LIMIT);
  localparam logic [10:0] YLim      = 11'(Y_LIMIT);
  localparam logic [18:0] MinPix    = 19'(MIN_PIXELS);
  localparam logic [18:0] CountMax  = 19'h7FFFF;
  localparam logic [4:0]  LastStep  = 5'd27;

  state_t      state_q, state_d;
  logic        vsPrev_q;
  logic        frameEnd, accepted, meetsMin;

  logic [18:0] accCount_q, accCount_d;
  logic [27:0] accSx_q, accSx_d, accSy_q, accSy_d;
  logic [9:0]  minX_q, minX_d, maxX_q, maxX_d, minY_q, minY_d, maxY_q, maxY_d;

  logic [18:0] snapCount_q;
  logic [27:0] snapSy_q;
  logic [9:0]  snapMinX_q, snapMaxX_q, snapMinY_q, snapMaxY_q;
  logic        snapFound_q;

  logic [27:0] dq_q, dqNext;
  logic [19:0] rem_q, remNext, remShift;
  logic        qBit;
  logic [4:0]  cnt_q;
  logic [9:0]  quotX_q, quotY_q;

  logic        snapLoad, publishSkip, publishDiv, divStep, divLast;

  logic [9:0]  centroidX_q, centroidY_q, bboxXMin_q, bboxXMax_q, bboxYMin_q, bboxYMax_q;
  logic [18:0] pixelCount_q;
  logic        found_q, resultValid_q, overrun_q;

  assign frameEnd = vsPrev_q & ~VGA_VS;
  assign accepted = pixel_valid & hit & ({1'b0, x} < XLim) & ({1'b0, y} < YLim);
  assign meetsMin = (accCount_q >= MinPix);

  // Accumulator next state: a frame end restarts from idle values, and a hit
  // on that same cycle already belongs to the new frame.
  always_comb begin
    accCount_d = accCount_q;
    accSx_d    = accSx_q;
    accSy_d    = accSy_q;
    minX_d     = minX_q;
    maxX_d     = maxX_q;
    minY_d     = minY_q;
    maxY_d     = maxY_q;
    if (frameEnd) begin
      accCount_d = '0;
      accSx_d    = '0;
      accSy_d    = '0;
      minX_d     = 10'd1023;
      maxX_d     = 10'd0;
      minY_d     = 10'd1023;
      maxY_d     = 10'd0;
    end
    if (accepted) begin
      if (accCount_d != CountMax) accCount_d = accCount_d + 19'd1;
      accSx_d = accSx_d + {18'd0, x};
      accSy_d = accSy_d + {18'd0, y};
      if (x < minX_d) minX_d = x;
      if (x > maxX_d) maxX_d = x;
      if (y < minY_d) minY_d = y;
      if (y > maxY_d) maxY_d = y;
    end
  end

  // Accumulator and frame-edge registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsPrev_q   <= 1'b0;
      accCount_q <= '0;
      accSx_q    <= '0;
      accSy_q    <= '0;
      minX_q     <= 10'd1023;
      maxX_q     <= 10'd0;
      minY_q     <= 10'd1023;
      maxY_q     <= 10'd0;
    end else begin
      vsPrev_q   <= VGA_VS;
      accCount_q <= accCount_d;
      accSx_q    <= accSx_d;
      accSy_q    <= accSy_d;
      minX_q     <= minX_d;
      maxX_q     <= maxX_d;
      minY_q     <= minY_d;
      maxY_q     <= maxY_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frameEnd) state_d = meetsMin ? DIV_X : DONE;
      DIV_X:   if (cnt_q == LastStep) state_d = DIV_Y;
      DIV_Y:   if (cnt_q == LastStep) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: small blobs publish straight from the accumulators at the
  // frame end; large blobs publish in DONE once both quotients are settled.
  always_comb begin
    busy        = (state_q != IDLE);
    snapLoad    = (state_q == IDLE) & frameEnd;
    publishSkip = snapLoad & ~meetsMin;
    publishDiv  = (state_q == DONE) & snapFound_q;
    divStep     = (state_q == DIV_X) | (state_q == DIV_Y);
    divLast     = divStep & (cnt_q == LastStep);
  end

  // One restoring-division step: shift in the next dividend bit, subtract
  // the count if it fits, and shift the quotient bit into the dividend slot.
  always_comb begin
    remShift = {rem_q[18:0], dq_q[27]};
    qBit     = (remShift >= {1'b0, snapCount_q});
    remNext  = qBit ? (remShift - {1'b0, snapCount_q}) : remShift;
    dqNext   = {dq_q[26:0], qBit};
  end

  // Snapshot and divider registers; x sum goes straight into the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapCount_q <= '0;
      snapSy_q    <= '0;
      snapMinX_q  <= '0;
      snapMaxX_q  <= '0;
      snapMinY_q  <= '0;
      snapMaxY_q  <= '0;
      snapFound_q <= 1'b0;
      dq_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotX_q     <= '0;
      quotY_q     <= '0;
    end else if (snapLoad) begin
      snapCount_q <= accCount_q;
      snapSy_q    <= accSy_q;
      snapMinX_q  <= minX_q;
      snapMaxX_q  <= maxX_q;
      snapMinY_q  <= minY_q;
      snapMaxY_q  <= maxY_q;
      snapFound_q <= meetsMin;
      dq_q        <= accSx_q;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else if (divStep) begin
      if (divLast) begin
        cnt_q <= '0;
        rem_q <= '0;
        if (state_q == DIV_X) begin
          quotX_q <= dqNext[9:0];
          dq_q    <= snapSy_q;
        end else begin
          quotY_q <= dqNext[9:0];
          dq_q    <= dqNext;
        end
      end else begin
        cnt_q <= cnt_q + 5'd1;
        rem_q <= remNext;
        dq_q  <= dqNext;
      end
    end
  end

  // Result registers, the result_valid pulse and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      centroidX_q   <= '0;
      centroidY_q   <= '0;
      bboxXMin_q    <= '0;
      bboxXMax_q    <= '0;
      bboxYMin_q    <= '0;
      bboxYMax_q    <= '0;
      pixelCount_q  <= '0;
      found_q       <= 1'b0;
      resultValid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      resultValid_q <= publishSkip | publishDiv;
      if (frameEnd && (state_q != IDLE)) overrun_q <= 1'b1;
      if (publishSkip) begin
        pixelCount_q <= accCount_q;
        bboxXMin_q   <= minX_q;
        bboxXMax_q   <= maxX_q;
        bboxYMin_q   <= minY_q;
        bboxYMax_q   <= maxY_q;
        found_q      <= 1'b0;
      end else if (publishDiv) begin
        pixelCount_q <= snapCount_q;
        bboxXMin_q   <= snapMinX_q;
        bboxXMax_q   <= snapMaxX_q;
        bboxYMin_q   <= snapMinY_q;
        bboxYMax_q   <= snapMaxY_q;
        found_q      <= 1'b1;
        centroidX_q  <= quotX_q;
        centroidY_q  <= quotY_q;
      end
    end
  end

  assign centroid_x   = centroidX_q;
  assign centroid_y   = centroidY_q;
  assign bbox_x_min   = bboxXMin_q;
  assign bbox_x_max   = bboxXMax_q;
  assign bbox_y_min   = bboxYMin_q;
  assign bbox_y_max   = bboxYMax_q;
  assign pixel_count  = pixelCount_q;
  assign found        = found_q;
  assign result_valid = resultValid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_blob_tracker.sv
// Directed testbench for blob_tracker with hand-computed expectations.
module tb_blob_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        VGA_VS;
  logic        pixel_valid;
  logic        hit;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  centroid_x, centroid_y;
  logic [9:0]  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [18:0] pixel_count;
  logic        found, result_valid, busy, overrun;

  int checks = 0;
  int errors = 0;
  int latency;
  int pulses;
  int firstLat;
  logic [18:0] capCount;
  logic [9:0]  capCx, capCy, capXMin, capYMax;

  blob_tracker dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pixel_valid(pixel_valid),
    .hit(hit), .x(x), .y(y),
    .centroid_x(centroid_x), .centroid_y(centroid_y),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .pixel_count(pixel_count), .found(found), .result_valid(result_valid),
    .busy(busy), .overrun(overrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vs, input logic valid, input logic h,
                               input logic [9:0] px, input logic [9:0] py);
    VGA_VS      = vs;
    pixel_valid = valid;
    hit         = h;
    x           = px;
    y           = py;
    stepCycle();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Steps until result_valid shows up; latency stays 0 if it never does.
  task automatic waitResult(output int lat);
    lat = 0;
    for (int n = 1; n <= 80; n++) begin
      stepCycle();
      pixel_valid = 1'b0;
      hit         = 1'b0;
      if (result_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; VGA_VS = 1'b1; pixel_valid = 1'b0; hit = 1'b0; x = '0; y = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("rst_count", 32'(pixel_count), 0);
    checkOutput("rst_cx", 32'(centroid_x), 0);
    checkOutput("rst_xmin", 32'(bbox_x_min), 0);
    checkOutput("rst_ymax", 32'(bbox_y_max), 0);
    checkOutput("rst_flags", {28'd0, found, result_valid, busy, overrun}, 0);

    // Empty first frame takes the skip path.
    VGA_VS = 1'b0;
    waitResult(latency);
    checkOutput("f1_latency", latency, 1);
    checkOutput("f1_count", 32'(pixel_count), 0);
    checkOutput("f1_found", 32'(found), 0);
    checkOutput("f1_xmin", 32'(bbox_x_min), 1023);
    checkOutput("f1_xmax", 32'(bbox_x_max), 0);
    checkOutput("f1_ymin", 32'(bbox_y_min), 1023);
    checkOutput("f1_busy_done", 32'(busy), 1);
    stepCycle();
    checkOutput("f1_pulse_end", 32'(result_valid), 0);
    checkOutput("f1_busy_idle", 32'(busy), 0);

    // 10x10 block: centroid floor(104.5)=104, floor(204.5)=204.
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        applyStimulus(1'b1, 1'b1, 1'b1, 10'(100 + j), 10'(200 + i));
    VGA_VS = 1'b0; pixel_valid = 1'b0; hit = 1'b0;
    waitResult(latency);
    checkOutput("f2_latency", latency, 58);
    checkOutput("f2_count", 32'(pixel_count), 100);
    checkOutput("f2_cx", 32'(centroid_x), 104);
    checkOutput("f2_cy", 32'(centroid_y), 204);
    checkOutput("f2_xmin", 32'(bbox_x_min), 100);
    checkOutput("f2_xmax", 32'(bbox_x_max), 109);
    checkOutput("f2_ymin", 32'(bbox_y_min), 200);
    checkOutput("f2_ymax", 32'(bbox_y_max), 209);
    checkOutput("f2_found", 32'(found), 1);
    stepCycle();
    checkOutput("f2_pulse_end", 32'(result_valid), 0);
    checkOutput("f2_hold_cx", 32'(centroid_x), 104);

    // Small blob: no division, centroid kept from previous frame.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd50, 10'd60);
    VGA_VS = 1'b0; pixel_valid = 1'b0; hit = 1'b0;
    waitResult(latency);
    checkOutput("f3_latency", latency, 1);
    checkOutput("f3_found", 32'(found), 0);
    checkOutput("f3_count", 32'(pixel_count), 10);
    checkOutput("f3_cx", 32'(centroid_x), 104);
    checkOutput("f3_cy", 32'(centroid_y), 204);
    checkOutput("f3_bbox", {bbox_x_min, bbox_x_max, bbox_y_min[5:0], bbox_y_max[5:0]},
                {10'd50, 10'd50, 6'd60, 6'd60});

    // Out-of-range hits only; a valid hit on the frame-end cycle.
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd700, 10'd10);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd640, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd5, 10'd480);
    VGA_VS = 1'b0; pixel_valid = 1'b1; hit = 1'b1; x = 10'd20; y = 10'd30;
    waitResult(latency);
    checkOutput("f4_latency", latency, 1);
    checkOutput("f4_count", 32'(pixel_count), 0);
    checkOutput("f4_xmin", 32'(bbox_x_min), 1023);
    checkOutput("f4_ymax", 32'(bbox_y_max), 0);

    // 63 more hits plus the carried one: exactly the minimum, divide path.
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd1, 10'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd2, 10'd2);
    for (int i = 0; i < 63; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd20, 10'd30);
    VGA_VS = 1'b0; pixel_valid = 1'b0; hit = 1'b0;
    waitResult(latency);
    checkOutput("f5_latency", latency, 58);
    checkOutput("f5_count", 32'(pixel_count), 64);
    checkOutput("f5_found", 32'(found), 1);
    checkOutput("f5_cx", 32'(centroid_x), 20);
    checkOutput("f5_cy", 32'(centroid_y), 30);
    checkOutput("f5_xmin", 32'(bbox_x_min), 20);

    // Second frame end while dividing: overrun, one result only.
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd300, 10'd100);
    VGA_VS = 1'b0; pixel_valid = 1'b0; hit = 1'b0;
    pulses = 0; firstLat = 0;
    capCount = '0; capCx = '0; capCy = '0; capXMin = '0; capYMax = '0;
    for (int n = 1; n <= 80; n++) begin
      stepCycle();
      if (n == 1) checkOutput("f6_overrun_before", 32'(overrun), 0);
      if (result_valid === 1'b1) begin
        pulses++;
        if (firstLat == 0) begin
          firstLat = n;
          capCount = pixel_count; capCx = centroid_x; capCy = centroid_y;
          capXMin = bbox_x_min; capYMax = bbox_y_max;
        end
      end
      if (n == 18) VGA_VS = 1'b1;
      if (n == 19) VGA_VS = 1'b0;
    end
    checkOutput("f6_latency", firstLat, 58);
    checkOutput("f6_pulses", pulses, 1);
    checkOutput("f6_overrun", 32'(overrun), 1);
    checkOutput("f6_count", 32'(capCount), 64);
    checkOutput("f6_cx", 32'(capCx), 300);
    checkOutput("f6_cy", 32'(capCy), 100);
    checkOutput("f6_xmin", 32'(capXMin), 300);
    checkOutput("f6_ymax", 32'(capYMax), 100);

    // Reset in the middle of the x division.
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 1'b1, 10'd10, 10'd10);
    VGA_VS = 1'b0; pixel_valid = 1'b0; hit = 1'b0;
    for (int i = 0; i < 11; i++) stepCycle();
    checkOutput("f7_busy_div", 32'(busy), 1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("f7_busy_reset", 32'(busy), 0);
    checkOutput("f7_flags", {28'd0, found, result_valid, busy, overrun}, 0);
    checkOutput("f7_count", 32'(pixel_count), 0);
    checkOutput("f7_cx", 32'(centroid_x), 0);
    checkOutput("f7_xmin", 32'(bbox_x_min), 0);
    pulses = 0;
    for (int n = 0; n < 70; n++) begin
      stepCycle();
      if (result_valid === 1'b1) pulses++;
    end
    checkOutput("f7_no_result", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
